sw_seq_store: RTL

- Sequence memory at the far end of the accelerator's SRAM read port. The accelerator drives sel_T/addr and samples the returned word.
- The host streams 2-bit nucleotide codes into either the T (database) bank or the Q (query) bank. The block packs the codes into words and writes a length header.
- It answers accelerator reads with a fixed 1-cycle latency.
- It sits between the host loader and the SmithWaterman top; busy_i is the accelerator's busy output.

---
 rtl/sw_seq_store_if.sv | 54 +++++
 rtl/sw_seq_store.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/sw_seq_store_if.sv
// Bundle between the host loader, the accelerator read port and the sequence store.
// The _i/_o suffixes are named from the store's point of view.
interface sw_seq_store_if #(
    parameter int WORD_WIDTH = 64,
    parameter int ADDR_BIT   = 10
);
    // Host loader side
    logic                  load_start_i;
    logic                  load_sel_T_i;
    logic [1:0]            sym_i;
    logic                  sym_valid_i;
    logic                  sym_last_i;
    logic                  load_ready_o;
    logic                  load_done_o;
    logic                  error_o;

    // Accelerator side
    logic                  busy_i;
    logic                  sel_T_i;
    logic [ADDR_BIT-1:0]   addr_i;
    logic [WORD_WIDTH-1:0] data_o;

    // The sequence store itself
    modport slave (
        input  load_start_i,
        input  load_sel_T_i,
        input  sym_i,
        input  sym_valid_i,
        input  sym_last_i,
        input  busy_i,
        input  sel_T_i,
        input  addr_i,
        output load_ready_o,
        output load_done_o,
        output error_o,
        output data_o
    );

    // Host loader plus accelerator, seen as one requester
    modport master (
        output load_start_i,
        output load_sel_T_i,
        output sym_i,
        output sym_valid_i,
        output sym_last_i,
        output busy_i,
        output sel_T_i,
        output addr_i,
        input  load_ready_o,
        input  load_done_o,
        input  error_o,
        input  data_o
    );
endinterface

// File: rtl/sw_seq_store.sv
// Two-bank (T / Q) nucleotide sequence store.
// The host streams 2-bit symbols in. They are packed into WORD_WIDTH-bit words from address 1
// upward, and word 0 receives the symbol count. The accelerator reads either bank through a
// registered read port that has a fixed latency of one cycle.
module sw_seq_store #(
    parameter int WORD_WIDTH = 64,
    parameter int ADDR_BIT   = 10,
    parameter int CNT_BIT    = ADDR_BIT + 5
) (
    input  logic          clk,
    input  logic          rst_n,
    sw_seq_store_if.slave bus
);
    localparam int SYMS     = WORD_WIDTH / 2;
    localparam int SLOT_BIT = (SYMS > 1) ? $clog2(SYMS) : 1;
    localparam int DEPTH    = 1 << ADDR_BIT;
    // Payload capacity: every word except the header, full of symbols.
    localparam int CAP_INT  = (DEPTH - 1) * SYMS;

    localparam logic [CNT_BIT-1:0]  CAP      = CNT_BIT'(CAP_INT);
    localparam logic [SLOT_BIT-1:0] SLOT_MAX = SLOT_BIT'(SYMS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FILL,
        S_FLUSH,
        S_HEADER
    } state_t;

    state_t                state_q, state_d;
    logic                  bank_q,  bank_d;
    logic [CNT_BIT-1:0]    cnt_q,   cnt_d;
    logic [SLOT_BIT-1:0]   slot_q,  slot_d;
    logic [ADDR_BIT-1:0]   waddr_q, waddr_d;
    logic [WORD_WIDTH-1:0] pack_q,  pack_d;
    logic                  err_q,   err_d;
    logic [WORD_WIDTH-1:0] data_q;

    logic                  wr_en;
    logic [ADDR_BIT-1:0]   wr_addr;
    logic [WORD_WIDTH-1:0] wr_data;
    logic                  load_ready;
    logic                  load_done;
    logic                  xfer;
    logic                  room;
    logic                  slot_full;
    logic [WORD_WIDTH-1:0] ins_word;

    // Both banks share one array. The MSB of the index selects T (1) or Q (0).
    logic [WORD_WIDTH-1:0] mem_q [0:2*DEPTH-1];

    // A symbol moves only while filling and while the accelerator is idle.
    assign xfer      = (state_q == S_FILL) && !bus.busy_i && bus.sym_valid_i;
    // When the bank is full, the remaining symbols are consumed but dropped.
    assign room      = (cnt_q != CAP);
    assign slot_full = (slot_q == SLOT_MAX);

    // The pack register with the incoming symbol dropped into its slot.
    // Slots above the current one are still zero, so a partial word is already padded.
    genvar gi;
    generate
        for (gi = 0; gi < SYMS; gi++) begin : g_slot
            assign ins_word[2*gi +: 2] = (slot_q == SLOT_BIT'(gi)) ? bus.sym_i
                                                                    : pack_q[2*gi +: 2];
        end
    endgenerate

    // Next-state, memory write and handshake decode for the loader FSM
    always_comb begin
        state_d    = state_q;
        bank_d     = bank_q;
        cnt_d      = cnt_q;
        slot_d     = slot_q;
        waddr_d    = waddr_q;
        pack_d     = pack_q;
        err_d      = err_q;
        wr_en      = 1'b0;
        wr_addr    = '0;
        wr_data    = '0;
        load_ready = 1'b0;
        load_done  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.load_start_i) begin
                    if (bus.busy_i) begin
                        err_d = 1'b1;
                    end else begin
                        bank_d  = bus.load_sel_T_i;
                        cnt_d   = '0;
                        slot_d  = '0;
                        waddr_d = ADDR_BIT'(1);
                        pack_d  = '0;
                        err_d   = 1'b0;
                        state_d = S_FILL;
                    end
                end
            end

            S_FILL: begin
                load_ready = !bus.busy_i;
                if (xfer) begin
                    if (room) begin
                        cnt_d = cnt_q + CNT_BIT'(1);
                        if (slot_full) begin
                            // The word is complete. Write it in the cycle of the transfer.
                            wr_en   = 1'b1;
                            wr_addr = waddr_q;
                            wr_data = ins_word;
                            pack_d  = '0;
                            slot_d  = '0;
                            waddr_d = waddr_q + ADDR_BIT'(1);
                        end else begin
                            pack_d  = ins_word;
                            slot_d  = slot_q + SLOT_BIT'(1);
                        end
                    end else begin
                        err_d = 1'b1;
                    end
                    if (bus.sym_last_i) begin
                        state_d = (slot_d != '0) ? S_FLUSH : S_HEADER;
                    end
                end
            end

            S_FLUSH: begin
                wr_en   = 1'b1;
                wr_addr = waddr_q;
                wr_data = pack_q;
                state_d = S_HEADER;
            end

            S_HEADER: begin
                wr_en     = 1'b1;
                wr_addr   = '0;
                wr_data   = WORD_WIDTH'(cnt_q);
                load_done = 1'b1;
                state_d   = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A new load cannot start on top of one that is still in progress.
        if (bus.load_start_i && (state_q != S_IDLE)) begin
            err_d = 1'b1;
        end
    end

    // Loader state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            bank_q  <= 1'b0;
            cnt_q   <= '0;
            slot_q  <= '0;
            waddr_q <= '0;
            pack_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            bank_q  <= bank_d;
            cnt_q   <= cnt_d;
            slot_q  <= slot_d;
            waddr_q <= waddr_d;
            pack_q  <= pack_d;
            err_q   <= err_d;
        end
    end

    // Bank storage: a single loader write port. The contents are not reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[{bank_q, wr_addr}] <= wr_data;
        end
    end

    // Registered accelerator read. A same-cycle write to the same word returns the old data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
        end else begin
            data_q <= mem_q[{bus.sel_T_i, bus.addr_i}];
        end
    end

    assign bus.load_ready_o = load_ready;
    assign bus.load_done_o  = load_done;
    assign bus.error_o      = err_q;
    assign bus.data_o       = data_q;

endmodule
